// File: rtl/node_memory_pkg.sv
// node_memory shared constants and types.
// Default geometry 16 x 8; DEPTH derived from ADDR_WIDTH.
package node_memory_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  // Number of words for a given address width.
  function automatic int depth_of(input int aw);
    return 2 ** aw;
  endfunction

endpackage

// File: rtl/node_memory_if.sv
// node_memory access bus: address, strobes, write and read data.
// The controller uses master, the memory uses slave.
interface node_memory_if #(
  parameter int DATA_WIDTH = node_memory_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = node_memory_pkg::ADDR_WIDTH
);

  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  write;
  logic                  read;
  logic [DATA_WIDTH-1:0] data_out;

  modport master (
    output addr,
    output data_in,
    output write,
    output read,
    input  data_out
  );

  modport slave (
    input  addr,
    input  data_in,
    input  write,
    input  read,
    output data_out
  );

endinterface

// File: rtl/node_memory_array.sv
// node_memory storage: resettable word array, one write port,
// one asynchronous read port.
module node_memory_array
  import node_memory_pkg::*;
#(
  parameter int DATA_WIDTH = node_memory_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = node_memory_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int Depth = depth_of(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  // Clear every word on reset; otherwise store on write strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/node_memory.sv
// node_memory top: registered read around the storage array.
// Optional NODE_MEMORY_FWD_EN gives write-first on read+write.
module node_memory
  import node_memory_pkg::*;
#(
  parameter int DATA_WIDTH = node_memory_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = node_memory_pkg::ADDR_WIDTH
) (
  input logic        clk,
  input logic        rst_n,
  node_memory_if.slave bus
);

  logic [DATA_WIDTH-1:0] rdata;
  logic [DATA_WIDTH-1:0] rd_d;
  logic [DATA_WIDTH-1:0] rd_q;

  node_memory_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (bus.write),
    .addr_i  (bus.addr),
    .wdata_i (bus.data_in),
    .rdata_o (rdata)
  );

  // Select the word loaded into the read register.
  always_comb begin
    rd_d = rd_q;
    if (bus.read) begin
`ifdef NODE_MEMORY_FWD_EN
      rd_d = bus.write ? bus.data_in : rdata;
`else
      rd_d = rdata;
`endif
    end
  end

  // Read register, cleared asynchronously with the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign bus.data_out = rd_q;

endmodule

// File: tb/tb_node_memory.sv
// Self-checking bench for node_memory: directed plan plus
// random traffic against an array model.
module tb_node_memory;
  import node_memory_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  word_t model_mem [DEPTH];
  word_t model_out;

`ifdef NODE_MEMORY_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  node_memory_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  node_memory #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    model_out = '0;
  endtask

  // One clock: drive at negedge, apply model at posedge, check after.
  task automatic cyc(input bit w, input bit r, input int a,
                     input word_t d, input string tag);
    @(negedge clk);
    bus.write   = w;
    bus.read    = r;
    bus.addr    = addr_t'(a);
    bus.data_in = d;
    @(posedge clk);
    if (r) model_out = (w && Fwd) ? d : model_mem[a];
    if (w) model_mem[a] = d;
    #1;
    chk(tag, bus.data_out, model_out);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, 1'b0, 0, '0, tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.write = 1'b0;
    bus.read = 1'b0;
    bus.addr = '0;
    bus.data_in = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("reset_out", bus.data_out, '0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, i, '0, "read_after_reset");
      chk("reset_zero", bus.data_out, 8'h00);
    end

    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b1, 1'b0, i, word_t'(2 * i), "fill_write");
      idle("fill_idle");
    end
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, i, '0, "fill_read");
      chk("fill_value", bus.data_out, word_t'(2 * i));
    end

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", bus.data_out, 8'h00);
    #9;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, i, '0, "read_after_midreset");
    end

    cyc(1'b1, 1'b0, 3, 8'hA5, "wr_a5");
    cyc(1'b0, 1'b1, 3, '0, "rd_a5");
    chk("rd_a5_const", bus.data_out, 8'hA5);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b0, 3, 8'h33, "hold_a5");
      chk("hold_a5_const", bus.data_out, 8'hA5);
    end

    cyc(1'b1, 1'b0, 7, 8'h0E, "wr_0e");
    cyc(1'b1, 1'b1, 7, 8'h55, "rw_same");
    chk("rw_same_const", bus.data_out, Fwd ? 8'h55 : 8'h0E);
    cyc(1'b0, 1'b1, 7, '0, "rw_after");
    chk("rw_after_const", bus.data_out, 8'h55);

    cyc(1'b1, 1'b0, 14, 8'h3C, "wr_14");
    cyc(1'b1, 1'b0, 1, 8'hC3, "wr_1");
    cyc(1'b1, 1'b0, 15, 8'hFF, "wr_top");
    cyc(1'b1, 1'b0, 0, 8'h01, "wr_bot");
    cyc(1'b0, 1'b1, 15, '0, "rd_top");
    chk("top_const", bus.data_out, 8'hFF);
    cyc(1'b0, 1'b1, 0, '0, "rd_bot");
    chk("bot_const", bus.data_out, 8'h01);
    cyc(1'b0, 1'b1, 14, '0, "rd_14");
    chk("nb14_const", bus.data_out, 8'h3C);
    cyc(1'b0, 1'b1, 1, '0, "rd_1");
    chk("nb1_const", bus.data_out, 8'hC3);

    for (int n = 0; n < 400; n++) begin
      cyc(1'($urandom), 1'($urandom), int'($urandom_range(DEPTH - 1)),
          word_t'($urandom), "random");
    end

    for (int i = 0; i < DEPTH; i++) begin
      cyc(1'b0, 1'b1, i, '0, "final_sweep");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
